// File: rtl/mem_dump_reader.sv
// mem_dump_reader: streams word_count words from base_addr of a sync-read memory as addr-tagged words; DUMP_CHECKSUM_EN adds a running checksum.
// Latency: first read 1 cycle after start, first word valid 3 cycles after start, then one word per cycle.
// Backpressure: out_ready low stops new reads once FIFO plus in-flight read fill 2 slots; head word holds stable.

// mdr_fifo: generic synchronous FIFO with simultaneous push/pop.
// Latency: pushed entry visible at pop_dat the cycle after push.
// Backpressure: push is dropped only if full without a same-cycle pop; callers keep it from filling.
module mdr_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  input  logic             pop_rdy,
  output logic             pop_vld,
  output logic [W-1:0]     pop_dat,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign pop_vld = (count_q != '0);
  assign pop_dat = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign do_pop  = pop_vld & pop_rdy;
  assign do_push = push_vld & ((count_q != CNT_W'(DEPTH)) | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module mem_dump_reader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic [DATA_W-1:0] checksum
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int ENT_W = $bits(entry_t);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] rd_left_q, rd_left_d;
  logic [ADDR_W-1:0] infl_addr_q, infl_addr_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic              rd_issue, hs, start_acc;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occ;
  entry_t            push_ent, head;

  assign push_ent = {infl_last_q, infl_addr_q, mem_rd_data};

  mdr_fifo #(.W(ENT_W), .DEPTH(2)) u_fifo (
    .core_clk (clk),
    .arst_n   (rst),
    .push_vld (infl_q),
    .push_dat (push_ent),
    .pop_rdy  (out_ready),
    .pop_vld  (out_valid),
    .pop_dat  (head),
    .count    (fifo_cnt)
  );

  assign hs        = out_valid & out_ready;
  assign start_acc = (state_q == IDLE) & start;

  // Slots committed after this cycle's pop; counting the pop keeps streaming bubble-free.
  assign occ      = {1'b0, fifo_cnt} + {2'b0, infl_q} - {2'b0, hs};
  assign rd_issue = (state_q == RUN) && (rd_left_q != '0) && (occ < 3'd2);

  assign busy      = (state_q == RUN);
  assign done      = (state_q == FIN);
  assign mem_rd_en = rd_issue;
  assign mem_addr  = rd_addr_q;
  assign out_data  = head.data;
  assign out_addr  = head.addr;
  assign out_last  = out_valid & head.last;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_left_d   = rd_left_q;
    infl_d      = rd_issue;
    infl_addr_d = rd_addr_q;
    infl_last_d = (rd_left_q == ADDR_W'(1));
    case (state_q)
      IDLE: begin
        if (start) begin
          rd_addr_d = base_addr;
          rd_left_d = word_count;
          state_d   = (word_count == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (rd_issue) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          rd_left_d = rd_left_q - ADDR_W'(1);
        end
        if (hs && head.last) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      rd_left_q   <= '0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_left_q   <= rd_left_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      infl_last_q <= infl_last_d;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (start_acc)  csum_d = '0;
    else if (hs)    csum_d = csum_q + head.data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) csum_q <= '0;
    else      csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
  assign checksum         = '0;
`endif
endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: table of dump scenarios checked cycle by cycle against a memory model and scoreboard.
// Also covers reset values and a mid-dump reset abort followed by a restart.
module tb_mem_dump_reader;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] word_count;
  logic          busy, done, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic          out_valid, out_ready, out_last;
  logic [DW-1:0] out_data, checksum;
  logic [AW-1:0] out_addr;

  always #5 clk = ~clk;

  mem_dump_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_last    (out_last),
    .checksum    (checksum)
  );

  logic [DW-1:0] mem [65536];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event at time %0t", name, $time);
  endtask

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          last;
  } word_t;

  word_t         exp_q[$];
  logic [AW-1:0] exp_rd_q[$];

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] cnt;
    int            st_lo;
    int            st_hi;
    int            s2;
    int            e_done;
    int            e_first;
    int            e_rd;
    int            e_rd_upto;
  } vec_t;

  // Cycle 0 presents start; out_ready is low for cycles st_lo..st_hi; s2 re-pulses start with base 0.
  task automatic run_dump(input logic [AW-1:0] base, input logic [AW-1:0] cnt,
                          input int st_lo, input int st_hi, input int s2,
                          output int done_cyc, output int n_done, output int first_vld,
                          output int rd_total, output int rd_upto, output int hold_err,
                          output int busy_err, output logic [DW-1:0] exp_sum);
    logic [DW+AW:0] snap, prev_snap;
    logic           prev_stall;
    logic           exp_busy;
    logic [AW-1:0]  a;
    done_cyc = -1; n_done = 0; first_vld = -1; rd_total = 0; rd_upto = 0;
    hold_err = 0; busy_err = 0; exp_sum = '0;
    prev_stall = 1'b0; prev_snap = '0;
    exp_q.delete();
    exp_rd_q.delete();
    for (int k = 0; k < int'(cnt); k++) begin
      a = base + AW'(k);
      exp_q.push_back('{data: mem[a], addr: a, last: (k == int'(cnt) - 1)});
      exp_rd_q.push_back(a);
      exp_sum = exp_sum + mem[a];
    end
`ifndef DUMP_CHECKSUM_EN
    exp_sum = '0;
`endif
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = base; word_count = cnt;
    out_ready = !(0 >= st_lo && 0 <= st_hi);
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        rd_total++;
        if (c <= st_hi) rd_upto++;
        if (exp_rd_q.size() == 0) fail_now("extra_read");
        else check("mem_addr", mem_addr, exp_rd_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("extra_word");
        else begin
          word_t e;
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_addr", out_addr, e.addr);
          check("out_last", out_last, e.last);
        end
      end
      snap = {out_data, out_addr, out_last};
      if (prev_stall && (!out_valid || snap != prev_snap)) hold_err++;
      prev_stall = out_valid && !out_ready;
      prev_snap  = snap;
      if (first_vld < 0 && out_valid) first_vld = c;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      exp_busy = (cnt != '0) && (c >= 1) && (done_cyc < 0);
      if (busy !== exp_busy) busy_err++;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      @(posedge clk);
      #1;
      start     = ((c + 1) == s2);
      base_addr = ((c + 1) == s2) ? '0 : base;
      out_ready = !((c + 1) >= st_lo && (c + 1) <= st_hi);
    end
    start = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    int            d_cyc, n_d, f_vld, rd_t, rd_u, h_err, b_err;
    logic [DW-1:0] e_sum;

    vecs[0] = '{16'd16,    16'd4, -1, -1, -1,  7,  3, 4, 0};  // basic
    vecs[1] = '{16'd16,    16'd4,  3,  9, -1, 14,  3, 4, 2};  // back-pressure
    vecs[2] = '{16'd16,    16'd0, -1, -1, -1,  1, -1, 0, 0};  // zero count
    vecs[3] = '{16'hFFFF,  16'd2, -1, -1, -1,  5,  3, 2, 0};  // address wrap
    vecs[4] = '{16'd16,    16'd4, -1, -1,  2,  7,  3, 4, 0};  // start while busy
    vecs[5] = '{16'd100,   16'd1,  3,  4, -1,  6,  3, 1, 1};  // single word, stalled
    vecs[6] = '{16'h0200,  16'd6,  5,  6, -1, 11,  3, 6, 4};  // mid-stream stall

    for (int i = 0; i < 65536; i++) mem[i] = DW'(i * 7 + 3) ^ 16'h5A5A;
    mem[16] = 16'hFFFC; mem[17] = 16'h0006; mem[18] = 16'h000D; mem[19] = 16'hFFF6;

    rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;
    #1;
    check("rst_busy",      busy,      1'b0);
    check("rst_done",      done,      1'b0);
    check("rst_rd_en",     mem_rd_en, 1'b0);
    check("rst_mem_addr",  mem_addr,  16'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last",  out_last,  1'b0);
    check("rst_out_data",  out_data,  16'h0);
    check("rst_out_addr",  out_addr,  16'h0);
    check("rst_checksum",  checksum,  16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_dump(vecs[v].base, vecs[v].cnt, vecs[v].st_lo, vecs[v].st_hi, vecs[v].s2,
               d_cyc, n_d, f_vld, rd_t, rd_u, h_err, b_err, e_sum);
      check($sformatf("v%0d_done_cycle", v), d_cyc, vecs[v].e_done);
      check($sformatf("v%0d_done_pulses", v), n_d, 1);
      check($sformatf("v%0d_first_valid", v), f_vld, vecs[v].e_first);
      check($sformatf("v%0d_reads", v), rd_t, vecs[v].e_rd);
      check($sformatf("v%0d_reads_by_stall_end", v), rd_u, vecs[v].e_rd_upto);
      check($sformatf("v%0d_hold_errors", v), h_err, 0);
      check($sformatf("v%0d_busy_errors", v), b_err, 0);
      check($sformatf("v%0d_words_left", v), exp_q.size(), 0);
      check($sformatf("v%0d_checksum", v), checksum, e_sum);
    end

    // Reset in cycle 4 of the basic dump, then a one-word restart.
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = 16'd16; word_count = 16'd4; out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    check("abort_pre_valid", out_valid, 1'b1);
    check("abort_pre_busy",  busy,      1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy",      busy,      1'b0);
    check("abort_done",      done,      1'b0);
    check("abort_rd_en",     mem_rd_en, 1'b0);
    check("abort_mem_addr",  mem_addr,  16'h0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_out_last",  out_last,  1'b0);
    check("abort_out_data",  out_data,  16'h0);
    check("abort_out_addr",  out_addr,  16'h0);
    check("abort_checksum",  checksum,  16'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_done", done, 1'b0);
    check("abort_no_valid", out_valid, 1'b0);

    run_dump(16'd16, 16'd1, -1, -1, -1, d_cyc, n_d, f_vld, rd_t, rd_u, h_err, b_err, e_sum);
    check("restart_done_cycle", d_cyc, 4);
    check("restart_first_valid", f_vld, 3);
    check("restart_reads", rd_t, 1);
    check("restart_words_left", exp_q.size(), 0);
    check("restart_checksum", checksum, e_sum);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
